// File: rtl/rk8e_data_break.sv
// Steals one memory cycle per RK8-E DMA request at a CPU break point, with a burst cap before a CPU fetch.
// dmaGNT arrives MEM_LAT+3 cycles after dmaREQ is sampled if the CPU yields at once; the device holds dmaREQ until dmaGNT.
module rk8e_data_break #(
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        cpu_break_ok,
  input  logic        cpu_fetch,
  output logic        cpu_hold,
  input  logic        dmaREQ,
  input  logic        dmaRD,
  input  logic        dmaWR,
  input  logic [14:0] dmaADDR,
  input  logic [11:0] dmaDOUT,
  output logic [11:0] dmaDIN,
  output logic        dmaGNT,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [11:0] mem_rdata,
  output logic        dma_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_MEM     = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LAT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [11:0]   din_q, din_d;
  logic [14:0]   addr_q, addr_d;
  logic [11:0]   wdata_q, wdata_d;
  logic          burst_ok;

  assign burst_ok = (burst_q < BURST_MAX);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    burst_d = burst_q;
    rd_d    = rd_q;
    err_d   = err_q;
    din_d   = din_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (dmaREQ) begin
          if (dmaRD != dmaWR) begin
            state_d = S_WAIT;
          end else begin
            // Ambiguous direction: flag it and grant without touching memory.
            err_d   = 1'b1;
            state_d = S_GRANT;
          end
        end
      end
      S_WAIT: begin
        if (!dmaREQ) begin
          state_d = S_IDLE;
        end else if (cpu_break_ok && burst_ok) begin
          addr_d  = dmaADDR;
          wdata_d = dmaDOUT;
          rd_d    = dmaRD;
          lat_d   = '0;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (lat_q == LAT_LAST) begin
          if (rd_q) din_d = mem_rdata;
          state_d = S_GRANT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_GRANT: begin
        if (burst_ok) burst_d = burst_q + 1'b1;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!dmaREQ) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A fetch proves the CPU made progress, so it outranks a coincident grant increment.
    if (cpu_fetch) burst_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      burst_q <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    cpu_hold = 1'b0;
    case (state_q)
      S_WAIT:                     cpu_hold = burst_ok;
      S_MEM, S_GRANT, S_RELEASE:  cpu_hold = 1'b1;
      default:                    cpu_hold = 1'b0;
    endcase
  end

  assign mem_re    = (state_q == S_MEM) && (lat_q == '0) && rd_q;
  assign mem_we    = (state_q == S_MEM) && (lat_q == '0) && !rd_q;
  assign dmaGNT    = (state_q == S_GRANT);
  assign dmaDIN    = din_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dma_err   = err_q;

endmodule

// File: doc/rk8e_data_break.md
Name: rk8e_data_break

Overview:
- CPU-side responder for the disk DMA handshake (dmaREQ/dmaGNT, dmaRD/dmaWR, dmaADDR, data both ways) driven by the SD disk engine inside the RK8-E.
- Steals one memory cycle per request at a CPU break point, performs the 15-bit extended-memory read or write, and returns dmaGNT.
- Enforces a burst limit so the CPU still executes instructions during long transfers.
- Sits between the RK8-E and the main memory port, replacing the registered dmaREQ→dmaGNT echo.

Parameters:
- MEM_LAT, 1, cycles from mem_re sample edge to mem_rdata valid (≥1).
- MAX_BURST, 4, consecutive breaks allowed before the CPU must complete a fetch (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  IOCLR/CAF; synchronous, same effect as reset
- cpu_break_ok  input  1  CPU is at a break point and can yield memory this cycle
- cpu_fetch  input  1  one-cycle pulse when the CPU begins an instruction fetch
- cpu_hold  output  1  CPU must stay parked at its break point
- dmaREQ  input  1  device request; held until dmaGNT is seen
- dmaRD  input  1  request is a memory read (memory→disk)
- dmaWR  input  1  request is a memory write (disk→memory)
- dmaADDR  input  15  memory address, [0:14], field in bits 0:2
- dmaDOUT  input  12  write data from disk, [0:11]
- dmaDIN  output  12  read data to disk, [0:11]
- dmaGNT  output  1  one-cycle grant: transfer complete
- mem_addr  output  15  memory address
- mem_wdata  output  12  memory write data
- mem_re  output  1  memory read strobe, one cycle
- mem_we  output  1  memory write strobe, one cycle
- mem_rdata  input  12  memory read data
- dma_err  output  1  sticky: request had dmaRD==dmaWR

Behaviour:
- Reset or clear in any state gives state IDLE and forces all outputs to 0: cpu_hold, dmaGNT, mem_re, mem_we, dma_err, dmaDIN, mem_addr, mem_wdata, burst_cnt.
- A reset or clear during MEM abandons the access with no grant. Only the already-issued one-cycle strobe may have occurred.
- States: IDLE, WAIT, MEM, GRANT, RELEASE.
- IDLE:
  - If dmaREQ=1 and dmaRD≠dmaWR, go to WAIT.
  - If dmaREQ=1 and dmaRD==dmaWR, set dma_err=1 and go to GRANT with no memory access and dmaDIN unchanged.
- WAIT:
  - cpu_hold = (burst_cnt<MAX_BURST).
  - If cpu_break_ok=1 and burst_cnt<MAX_BURST: latch dmaADDR into mem_addr, dmaDOUT into mem_wdata, and direction; go to MEM.
  - Otherwise stay in WAIT.
  - If dmaREQ drops while in WAIT, return to IDLE. This is a protocol violation and is tolerated.
- MEM:
  - Lasts MEM_LAT+1 cycles, timed by an internal counter.
  - First cycle only: mem_re=1 for a read, or mem_we=1 for a write.
  - On the edge ending the last cycle of a read, capture mem_rdata into dmaDIN.
  - Then go to GRANT.
- GRANT: dmaGNT=1 for exactly one cycle; burst_cnt increments, saturating at MAX_BURST; go to RELEASE.
- RELEASE:
  - Wait for dmaREQ=0, then go to IDLE.
  - A request must fall for at least one cycle before the next one is accepted, so there is no double grant on a held request.
- cpu_hold=1 in MEM, GRANT and RELEASE, and in WAIT as above. cpu_hold=0 in IDLE.
- burst_cnt clears on cpu_fetch=1. If cpu_fetch coincides with GRANT, the clear wins and the count becomes 0.
- dmaDIN holds the last read value until the next read capture. mem_addr and mem_wdata hold after the access.
- dma_err clears only on reset or clear.
- Latency with cpu_break_ok held high:
  - dmaREQ sampled in IDLE at edge 0 → WAIT; MEM from edge 1; GRANT after edge 1+MEM_LAT+1.
  - With defaults, dmaGNT is high in the 4th cycle after dmaREQ is first sampled.

Test Plan:
- Write: dmaWR=1, dmaADDR=15'o12345, dmaDOUT=12'o7070, cpu_break_ok=1 → one mem_we pulse with mem_addr=12345, mem_wdata=7070; dmaGNT 1 cycle, 4 cycles after request with defaults; no mem_re.
- Read: memory[15'o00200]=12'o4321, dmaRD=1 → single mem_re; dmaDIN=4321 when dmaGNT=1; dmaDIN stays 4321 after dmaREQ drops.
- Break stall: cpu_break_ok=0 for 10 cycles after dmaREQ → cpu_hold=1 and no strobes throughout; access starts the cycle after cpu_break_ok rises.
- Burst limit: 6 back-to-back writes, no cpu_fetch → exactly 4 grants; cpu_hold=0 while the 5th waits; cpu_fetch pulse → 5th and 6th complete.
- Illegal request: dmaRD=dmaWR=1 → dma_err=1, dmaGNT pulses, no mem_re/mem_we; clear → dma_err=0.
- Reset mid-MEM with MEM_LAT=3: assert reset in the 2nd MEM cycle → no dmaGNT, all outputs 0, IDLE; next request serviced normally.
